// File: rtl/sixteen_to_four_priority_encoder.sv
// Registered N:log2(N) priority encoder with a one-entry valid/ready output register.
// Define PRIO_ENC_ROUND_ROBIN_EN to replace fixed MSB-first priority with round-robin arbitration.
module sixteen_to_four_priority_encoder #(
  parameter int N     = 16,
  parameter int W     = $clog2(N),
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     req,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     code,
  output logic             any,
  output logic             multi,
  output logic [CNT_W-1:0] multi_cnt
);

  logic [N-1:0] g;
  logic [W-1:0] code_next;
  logic         any_next;
  logic         multi_next;
  logic         in_xfer;
  logic         out_xfer;

  assign in_ready = !out_valid || out_ready;
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  assign g        = en ? req : '0;
  assign any_next = |g;
  // Clearing the lowest set bit leaves something behind only when two or more bits are set.
  assign multi_next = |(g & (g - N'(1)));

`ifdef PRIO_ENC_ROUND_ROBIN_EN
  logic [W-1:0] ptr;
  logic [W-1:0] idx;
  logic         found;

  // Scan upward from ptr; W-bit addition wraps N-1 back to 0 because N is a power of two.
  always_comb begin
    code_next = '0;
    idx       = '0;
    found     = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = ptr + W'(k);
      if (!found && g[idx]) begin
        code_next = idx;
        found     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (in_xfer && any_next) begin
      ptr <= code_next + W'(1);
    end
  end
`else
  always_comb begin
    code_next = '0;
    for (int i = 0; i < N; i++) begin
      if (g[i]) begin
        code_next = W'(i);
      end
    end
  end
`endif

  // Reloading on an input transfer takes precedence so a simultaneous drain keeps out_valid high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      code      <= '0;
      any       <= 1'b0;
      multi     <= 1'b0;
    end else if (in_xfer) begin
      out_valid <= 1'b1;
      code      <= code_next;
      any       <= any_next;
      multi     <= multi_next;
    end else if (out_xfer) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      multi_cnt <= '0;
    end else if (in_xfer && multi_next && (multi_cnt != {CNT_W{1'b1}})) begin
      multi_cnt <= multi_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_sixteen_to_four_priority_encoder.sv
// Self-checking bench for sixteen_to_four_priority_encoder: vector table, corner sequences, random traffic.
// Honours PRIO_ENC_ROUND_ROBIN_EN to select the matching reference behaviour.
module tb_sixteen_to_four_priority_encoder;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        in_valid;
  logic        out_ready;
  logic [15:0] req;

  logic        in_ready,  out_valid,  any,  multi;
  logic [3:0]  code;
  logic [7:0]  multi_cnt;
  logic        s_in_ready, s_out_valid, s_any, s_multi;
  logic [3:0]  s_code;
  logic [1:0]  s_multi_cnt;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  bit m_valid;
  int m_code;
  bit m_any;
  bit m_multi;
  int m_cnt;
  int m_cnt2;
  int m_ptr;

  typedef struct {
    logic        en;
    logic [15:0] req;
    int          code;
    logic        any;
    logic        multi;
  } vec_t;

  vec_t vecs[$];

  sixteen_to_four_priority_encoder dut (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_ready(in_ready),
    .req(req), .out_valid(out_valid), .out_ready(out_ready), .code(code),
    .any(any), .multi(multi), .multi_cnt(multi_cnt)
  );

  sixteen_to_four_priority_encoder #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_ready(s_in_ready),
    .req(req), .out_valid(s_out_valid), .out_ready(out_ready), .code(s_code),
    .any(s_any), .multi(s_multi), .multi_cnt(s_multi_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int highestSet(input logic [15:0] v);
    for (int i = 15; i >= 0; i--) if (v[i]) return i;
    return 0;
  endfunction

  function automatic int rrPick(input logic [15:0] v, input int p);
    for (int k = 0; k < 16; k++) if (v[(p + k) % 16]) return (p + k) % 16;
    return 0;
  endfunction

  task automatic modelReset();
    m_valid = 0; m_code = 0; m_any = 0; m_multi = 0;
    m_cnt = 0; m_cnt2 = 0; m_ptr = 0;
  endtask

  task automatic modelStep();
    bit          xin;
    bit          xout;
    logic [15:0] g;
    xin  = in_valid && (!m_valid || out_ready);
    xout = m_valid && out_ready;
    if (xin) begin
      g       = en ? req : 16'h0;
      m_any   = (g != 16'h0);
      m_multi = ($countones(g) >= 2);
`ifdef PRIO_ENC_ROUND_ROBIN_EN
      m_code = m_any ? rrPick(g, m_ptr) : 0;
      if (m_any) m_ptr = (m_code + 1) % 16;
`else
      m_code = highestSet(g);
`endif
      if (m_multi && m_cnt < 255) m_cnt = m_cnt + 1;
      if (m_multi && m_cnt2 < 3) m_cnt2 = m_cnt2 + 1;
      m_valid = 1;
    end else if (xout) begin
      m_valid = 0;
    end
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string name);
    bit exp_ready;
    exp_ready = !m_valid || out_ready;
    cmp({name, ".out_valid"}, 32'(out_valid), 32'(m_valid));
    cmp({name, ".code"}, 32'(code), 32'(m_code));
    cmp({name, ".any"}, 32'(any), 32'(m_any));
    cmp({name, ".multi"}, 32'(multi), 32'(m_multi));
    cmp({name, ".multi_cnt"}, 32'(multi_cnt), 32'(m_cnt));
    cmp({name, ".in_ready"}, 32'(in_ready), 32'(exp_ready));
    cmp({name, ".sat_cnt"}, 32'(s_multi_cnt), 32'(m_cnt2));
    cmp({name, ".sat_code"}, 32'(s_code), 32'(m_code));
  endtask

  task automatic applyStimulus(input logic v, input logic e, input logic [15:0] r, input logic ordy);
    in_valid  = v;
    en        = e;
    req       = r;
    out_ready = ordy;
  endtask

  task automatic tick(input string name);
    @(posedge clk);
    modelStep();
    #1;
    checkOutput(name);
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b0);
    rst_n = 1'b0;
    modelReset();
    #1;
    checkOutput("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    vec_t        v;
    logic [15:0] onehot;
    int          exp_seq[$];

    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b0);
    modelReset();

    // Vector table: one-hot sweep, gated input, multi-hot, all-zero
    for (int i = 0; i < 16; i++) begin
      onehot = 16'h1 << i;
      vecs.push_back('{1'b1, onehot, i, 1'b1, 1'b0});
    end
    vecs.push_back('{1'b0, 16'hFFFF, 0, 1'b0, 1'b0});
`ifdef PRIO_ENC_ROUND_ROBIN_EN
    vecs.push_back('{1'b1, 16'h8421, 0, 1'b1, 1'b1});
`else
    vecs.push_back('{1'b1, 16'h8421, 15, 1'b1, 1'b1});
`endif
    vecs.push_back('{1'b1, 16'h0000, 0, 1'b0, 1'b0});

    doReset();
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      applyStimulus(1'b1, v.en, v.req, 1'b1);
      tick($sformatf("vec%0d", i));
      cmp($sformatf("vec%0d.tbl_code", i), 32'(code), 32'(v.code));
      cmp($sformatf("vec%0d.tbl_any", i), 32'(any), 32'(v.any));
      cmp($sformatf("vec%0d.tbl_multi", i), 32'(multi), 32'(v.multi));
    end
    cmp("table.multi_cnt", 32'(multi_cnt), 32'd1);

    // Backpressure: pending result must hold, then drain and reload on the same edge
    applyStimulus(1'b1, 1'b1, 16'h0100, 1'b1);
    tick("bp_load");
    applyStimulus(1'b1, 1'b1, 16'h0002, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick($sformatf("bp_hold%0d", i));
      cmp($sformatf("bp_hold%0d.code_stable", i), 32'(code), 32'd8);
      cmp($sformatf("bp_hold%0d.in_ready_low", i), 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick("bp_release");
    cmp("bp_release.code", 32'(code), 32'd1);
    cmp("bp_release.out_valid", 32'(out_valid), 32'd1);
    applyStimulus(1'b0, 1'b1, 16'hFFFF, 1'b1);
    tick("bp_drain");
    cmp("bp_drain.out_valid", 32'(out_valid), 32'd0);
    cmp("bp_drain.code_hold", 32'(code), 32'd1);

    // Arbitration sequences, each from a fresh reset
    doReset();
`ifdef PRIO_ENC_ROUND_ROBIN_EN
    exp_seq = '{0, 4, 0, 4};
`else
    exp_seq = '{4, 4, 4, 4};
`endif
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b1, 16'h0011, 1'b1);
      tick($sformatf("seq11_%0d", i));
      cmp($sformatf("seq11_%0d.exp_code", i), 32'(code), 32'(exp_seq[i]));
    end
    doReset();
`ifdef PRIO_ENC_ROUND_ROBIN_EN
    exp_seq = '{0, 15, 0};
`else
    exp_seq = '{15, 15, 15};
`endif
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b1, 16'h8001, 1'b1);
      tick($sformatf("seqwrap_%0d", i));
      cmp($sformatf("seqwrap_%0d.exp_code", i), 32'(code), 32'(exp_seq[i]));
    end

    // Saturation of the 2-bit counter instance, then asynchronous reset mid-stream
    doReset();
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 1'b1, 16'h0003, 1'b1);
      tick($sformatf("sat%0d", i));
    end
    cmp("sat.small_cnt", 32'(s_multi_cnt), 32'd3);
    cmp("sat.wide_cnt", 32'(multi_cnt), 32'd6);
    @(posedge clk);
    modelStep();
    #3;
    rst_n = 1'b0;
    modelReset();
    #1;
    cmp("async_rst.out_valid", 32'(out_valid), 32'd0);
    cmp("async_rst.code", 32'(code), 32'd0);
    cmp("async_rst.multi_cnt", 32'(multi_cnt), 32'd0);
    cmp("async_rst.small_cnt", 32'(s_multi_cnt), 32'd0);
    cmp("async_rst.multi", 32'(multi), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic against the reference model
    doReset();
    for (int i = 0; i < 400; i++) begin
      int mode;
      logic [15:0] r;
      mode = $urandom_range(0, 3);
      case (mode)
        0:       r = 16'h0;
        1:       r = 16'h1 << $urandom_range(0, 15);
        default: r = 16'($urandom);
      endcase
      applyStimulus(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) != 0), r,
                    1'($urandom_range(0, 2) != 0));
      tick($sformatf("rand%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
